lsu_mem_master: RTL and testbench
=================================

Name: lsu_mem_master

Overview:
- Core-side initiator for the data memory port. It drives the memory modport signals: rd_addr0, wr_addr0, wr_din0, we0, wr_strb; it receives rd_dout0.
- Accepts one RV32I load/store at a time from the execute stage over a valid/ready handshake and returns one response per request.
- Memory is word-organised (MEM_DEPTH x 32), with a synchronous 1-cycle read and a single-cycle write.
- Sub-word stores are done as read-modify-write inside this block, so the memory only ever sees full-word writes.

Parameters:
- MEM_DEPTH, 4, number of 32-bit words in the target memory. Local AW = $clog2(MEM_DEPTH), the word-index width.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  block can accept; high only in IDLE
- req_we  input  1  1 = store, 0 = load
- req_funct3  input  3  RV32I funct3 (LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010)
- req_addr  input  32  byte address
- req_wdata  input  32  store data, right-aligned
- rsp_valid  output  1  one-cycle response pulse
- rsp_rdata  output  32  load result, extended; 0 for stores and errors
- rsp_err  output  1  qualifies rsp_valid; misaligned, out-of-range or illegal funct3
- rd_addr0  output  AW  memory read word index
- wr_addr0  output  AW  memory write word index
- wr_din0  output  32  memory write data
- we0  output  1  memory write enable
- wr_strb  output  3  write size code; this block always drives 3'b010 (word)
- rd_dout0  input  32  memory read data, valid the cycle after rd_addr0 is presented

Behaviour:
- Reset (async): state=IDLE, req_ready=1, rsp_valid=0, rsp_err=0, rsp_rdata=0, we0=0, rd_addr0=0, wr_addr0=0, wr_din0=0, wr_strb=3'b010. Internal latches cleared.
- Reset mid-operation aborts the request. we0 drops immediately, no response is issued, and a partially merged RMW word is never written.
- Accept: on req_valid && req_ready, latch we/funct3/addr/wdata. Word index = addr[AW+1:2], byte offset = addr[1:0].
- Error check at accept; an error request goes IDLE->RSP with rsp_err=1, rsp_rdata=0 and no memory traffic. Error conditions:
  - addr[31:AW+2] != 0;
  - halfword with addr[0]=1;
  - word with addr[1:0] != 0;
  - load funct3 in {011,110,111};
  - store funct3 not in {000,001,010}.
- FSM states: IDLE, LD_ADDR, LD_DATA, ST_WR, RSP.
- Load path IDLE->LD_ADDR->LD_DATA->RSP:
  - LD_ADDR: rd_addr0 = word index.
  - LD_DATA: sample rd_dout0, select the byte/half by offset, then sign-extend (LB/LH) or zero-extend (LBU/LHU).
  - RSP: rsp_valid=1 for exactly 1 cycle.
  - Latency: rsp_valid 3 cycles after the accept edge.
- SW path IDLE->ST_WR->RSP. In ST_WR: we0=1, wr_addr0=index, wr_din0=wdata. Response 2 cycles after accept.
- SB/SH path IDLE->LD_ADDR->LD_DATA->ST_WR->RSP:
  - LD_DATA: merge the low byte/half of wdata into rd_dout0 at the offset; other bytes are preserved.
  - ST_WR: writes the merged word.
  - Response 4 cycles after accept.
- we0 is high only in ST_WR, exactly one cycle per store. It is never asserted for loads or errors.
- rsp_rdata and rsp_err are held stable only while rsp_valid=1; otherwise they are 0.
- RSP always returns to IDLE. req_ready rises the cycle after rsp_valid.
- Back-to-back: a new request may be accepted in the cycle after RSP.
- req_valid while not ready is ignored. The requester holds its request until it is accepted.
- Outputs rd_addr0/wr_addr0/wr_din0 hold their last value when not in use.

Test Plan:
- Reset then LW at addr 0x4, mem[1]=0xDEADBEEF -> rsp_valid 3 cycles after accept, rsp_rdata=0xDEADBEEF, rsp_err=0, we0 never high.
- LB at 0x7 and LBU at 0x7, mem[1]=0x80FF1234 -> rsp_rdata=0xFFFFFF80, then 0x00000080.
- SB 0xAB at 0x5, mem[1]=0x11223344 -> one we0 pulse, wr_addr0=1, wr_din0=0x1122AB44, response 4 cycles after accept; a following LW at 0x4 returns 0x1122AB44.
- SW 0x0BADF00D at 0xC -> we0 one cycle, wr_addr0=3, response 2 cycles after accept.
- Error cases, each giving rsp_err=1, rsp_rdata=0, no we0, response the cycle after accept:
  - LH at 0x3;
  - SW at 0x2;
  - LW at 0x10 (MEM_DEPTH=4);
  - load funct3=011.
- Assert rst during ST_WR of an SH -> we0 low asynchronously, no rsp_valid, req_ready=1; memory word unchanged.

Source files
------------

// File: rtl/lsu_mem_master.sv
// lsu_mem_master: single-outstanding RV32I load/store initiator, sub-word stores done as read-modify-write
module lsu_mem_master #(
  parameter int MEM_DEPTH = 4,
  localparam int AW = $clog2(MEM_DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [2:0]    req_funct3,
  input  logic [31:0]   req_addr,
  input  logic [31:0]   req_wdata,
  output logic          rsp_valid,
  output logic [31:0]   rsp_rdata,
  output logic          rsp_err,
  output logic [AW-1:0] rd_addr0,
  output logic [AW-1:0] wr_addr0,
  output logic [31:0]   wr_din0,
  output logic          we0,
  output logic [2:0]    wr_strb,
  input  logic [31:0]   rd_dout0
);
  typedef enum logic [2:0] {IDLE, LD_ADDR, LD_DATA, ST_WR, RSP} state_t;
  state_t        state;
  logic          st_q;
  logic [2:0]    f3_q;
  logic [1:0]    off_q;
  logic [AW-1:0] idx_q;
  logic [31:0]   wd_q;
  logic [AW-1:0] idx;
  logic          err;
  logic [7:0]    b;
  logic [15:0]   h;
  logic [31:0]   ld, mask, mrg;
  assign wr_strb = 3'b010;
  assign idx = req_addr[AW+1:2];
  assign err = ((req_addr >> (AW + 2)) != 32'd0)
             | (req_funct3[1:0] == 2'b01 && req_addr[0])
             | (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00)
             | (req_we ? req_funct3 > 3'b010 : (req_funct3 == 3'b011 || req_funct3[2:1] == 2'b11));
  always_comb begin
    b = rd_dout0[{off_q, 3'b000} +: 8];
    h = rd_dout0[{off_q[1], 4'b0000} +: 16];
    ld = f3_q[1] ? rd_dout0 : f3_q[0] ? {{16{~f3_q[2] & h[15]}}, h} : {{24{~f3_q[2] & b[7]}}, b};
    mask = (f3_q[0] ? 32'h0000_ffff : 32'h0000_00ff) << {off_q, 3'b000};
    mrg = (rd_dout0 & ~mask) | ((wd_q << {off_q, 3'b000}) & mask);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_err <= 1'b0;
      rsp_rdata <= '0;
      we0 <= 1'b0;
      rd_addr0 <= '0;
      wr_addr0 <= '0;
      wr_din0 <= '0;
      st_q <= 1'b0;
      f3_q <= '0;
      off_q <= '0;
      idx_q <= '0;
      wd_q <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          req_ready <= 1'b0;
          st_q <= req_we;
          f3_q <= req_funct3;
          off_q <= req_addr[1:0];
          idx_q <= idx;
          wd_q <= req_wdata;
          if (err) begin
            state <= RSP;
            rsp_valid <= 1'b1;
            rsp_err <= 1'b1;
          end else if (req_we && req_funct3 == 3'b010) begin
            state <= ST_WR;
            we0 <= 1'b1;
            wr_addr0 <= idx;
            wr_din0 <= req_wdata;
          end else begin
            state <= LD_ADDR;
            rd_addr0 <= idx;
          end
        end
        LD_ADDR: state <= LD_DATA;
        LD_DATA: if (st_q) begin
          state <= ST_WR;
          we0 <= 1'b1;
          wr_addr0 <= idx_q;
          wr_din0 <= mrg;
        end else begin
          state <= RSP;
          rsp_valid <= 1'b1;
          rsp_rdata <= ld;
        end
        ST_WR: begin
          state <= RSP;
          we0 <= 1'b0;
          rsp_valid <= 1'b1;
        end
        RSP: begin
          state <= IDLE;
          rsp_valid <= 1'b0;
          rsp_err <= 1'b0;
          rsp_rdata <= '0;
          req_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_mem_master.sv
// tb_lsu_mem_master: directed self-checking bench for lsu_mem_master
module tb_lsu_mem_master;
  localparam int AW = 2;
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [2:0]    req_funct3 = '0;
  logic [31:0]   req_addr = '0;
  logic [31:0]   req_wdata = '0;
  logic          rsp_valid;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;
  logic [AW-1:0] rd_addr0;
  logic [AW-1:0] wr_addr0;
  logic [31:0]   wr_din0;
  logic          we0;
  logic [2:0]    wr_strb;
  logic [31:0]   rd_dout0;
  logic [31:0]   mem [4];
  logic          pre_we = 1'b0;
  logic [1:0]    pre_a = '0;
  logic [31:0]   pre_d = '0;
  int            errors = 0;
  int            checks = 0;
  int            lat, wes;
  logic [31:0]   rd, wdo;
  logic          er;
  logic [1:0]    wa;

  lsu_mem_master #(.MEM_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rd_addr0(rd_addr0), .wr_addr0(wr_addr0), .wr_din0(wr_din0), .we0(we0), .wr_strb(wr_strb),
    .rd_dout0(rd_dout0)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pre_we) mem[pre_a] <= pre_d;
    else if (we0) mem[wr_addr0] <= wr_din0;
    rd_dout0 <= mem[rd_addr0];
  end

  task automatic preload(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_a = a; pre_d = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                        output int l, output logic [31:0] r, output logic e, output int w,
                        output logic [1:0] wadr, output logic [31:0] wdat);
    int n;
    l = 0; w = 0; r = 'x; e = 'x; wadr = 'x; wdat = 'x; n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int i = 1; i <= 8 && l == 0; i++) begin
      if (we0) begin w++; wadr = wr_addr0; wdat = wr_din0; end
      if (rsp_valid) begin l = i; r = rsp_rdata; e = rsp_err; end
      if (l == 0) begin @(posedge clk); #1; end
    end
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b want 1", req_ready); end
    checks++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin errors++; $display("FAIL rst_rsp got v=%b e=%b d=%h want 0 0 0", rsp_valid, rsp_err, rsp_rdata); end
    checks++; if (we0 !== 1'b0 || rd_addr0 !== 2'd0 || wr_addr0 !== 2'd0 || wr_din0 !== 32'h0) begin errors++; $display("FAIL rst_mem got we=%b ra=%0d wa=%0d wd=%h want all 0", we0, rd_addr0, wr_addr0, wr_din0); end
    checks++; if (wr_strb !== 3'b010) begin errors++; $display("FAIL rst_strb got %b want 010", wr_strb); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_lw;
    preload(2'd1, 32'hDEADBEEF);
    do_req(1'b0, 3'b010, 32'h4, 32'h0, lat, rd, er, wes, wa, wdo);
    checks++; if (lat !== 3) begin errors++; $display("FAIL lw_lat got %0d want 3", lat); end
    checks++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin errors++; $display("FAIL lw_data got %h err=%b want deadbeef 0", rd, er); end
    checks++; if (wes !== 0) begin errors++; $display("FAIL lw_we got %0d pulses want 0", wes); end
  endtask

  task automatic test_lb_lbu;
    preload(2'd1, 32'h80FF1234);
    do_req(1'b0, 3'b000, 32'h7, 32'h0, lat, rd, er, wes, wa, wdo);
    checks++; if (lat !== 3 || rd !== 32'hFFFFFF80 || er !== 1'b0) begin errors++; $display("FAIL lb got lat=%0d d=%h e=%b want 3 ffffff80 0", lat, rd, er); end
    do_req(1'b0, 3'b100, 32'h7, 32'h0, lat, rd, er, wes, wa, wdo);
    checks++; if (lat !== 3 || rd !== 32'h00000080 || er !== 1'b0) begin errors++; $display("FAIL lbu got lat=%0d d=%h e=%b want 3 00000080 0", lat, rd, er); end
    do_req(1'b0, 3'b000, 32'h5, 32'h0, lat, rd, er, wes, wa, wdo);
    checks++; if (rd !== 32'h00000012) begin errors++; $display("FAIL lb_off1 got %h want 00000012", rd); end
  endtask

  task automatic test_sb;
    preload(2'd1, 32'h11223344);
    do_req(1'b1, 3'b000, 32'h5, 32'h000000AB, lat, rd, er, wes, wa, wdo);
    checks++; if (lat !== 4) begin errors++; $display("FAIL sb_lat got %0d want 4", lat); end
    checks++; if (wes !== 1 || wa !== 2'd1 || wdo !== 32'h1122AB44) begin errors++; $display("FAIL sb_wr got n=%0d a=%0d d=%h want 1 1 1122ab44", wes, wa, wdo); end
    checks++; if (rd !== 32'h0 || er !== 1'b0) begin errors++; $display("FAIL sb_rsp got d=%h e=%b want 0 0", rd, er); end
    do_req(1'b0, 3'b010, 32'h4, 32'h0, lat, rd, er, wes, wa, wdo);
    checks++; if (rd !== 32'h1122AB44) begin errors++; $display("FAIL sb_readback got %h want 1122ab44", rd); end
  endtask

  task automatic test_sw_half;
    do_req(1'b1, 3'b010, 32'hC, 32'h0BADF00D, lat, rd, er, wes, wa, wdo);
    checks++; if (lat !== 2) begin errors++; $display("FAIL sw_lat got %0d want 2", lat); end
    checks++; if (wes !== 1 || wa !== 2'd3 || wdo !== 32'h0BADF00D) begin errors++; $display("FAIL sw_wr got n=%0d a=%0d d=%h want 1 3 0badf00d", wes, wa, wdo); end
    checks++; if (mem[3] !== 32'h0BADF00D) begin errors++; $display("FAIL sw_mem got %h want 0badf00d", mem[3]); end
    do_req(1'b0, 3'b001, 32'hC, 32'h0, lat, rd, er, wes, wa, wdo);
    checks++; if (rd !== 32'hFFFFF00D) begin errors++; $display("FAIL lh got %h want fffff00d", rd); end
    do_req(1'b0, 3'b101, 32'hC, 32'h0, lat, rd, er, wes, wa, wdo);
    checks++; if (rd !== 32'h0000F00D) begin errors++; $display("FAIL lhu got %h want 0000f00d", rd); end
    do_req(1'b0, 3'b001, 32'hE, 32'h0, lat, rd, er, wes, wa, wdo);
    checks++; if (rd !== 32'h00000BAD) begin errors++; $display("FAIL lh_hi got %h want 00000bad", rd); end
    do_req(1'b1, 3'b001, 32'hE, 32'h0000BEEF, lat, rd, er, wes, wa, wdo);
    checks++; if (lat !== 4 || wes !== 1 || wdo !== 32'hBEEFF00D) begin errors++; $display("FAIL sh_wr got lat=%0d n=%0d d=%h want 4 1 beeff00d", lat, wes, wdo); end
  endtask

  task automatic test_errors;
    logic        ew [5];
    logic [2:0]  ef [5];
    logic [31:0] ea [5];
    ew = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    ef = '{3'b001, 3'b010, 3'b010, 3'b011, 3'b100};
    ea = '{32'h3, 32'h2, 32'h10, 32'h0, 32'h0};
    for (int k = 0; k < 5; k++) begin
      do_req(ew[k], ef[k], ea[k], 32'hFFFFFFFF, lat, rd, er, wes, wa, wdo);
      checks++; if (lat !== 1 || er !== 1'b1 || rd !== 32'h0 || wes !== 0) begin errors++; $display("FAIL err_case%0d got lat=%0d e=%b d=%h we=%0d want 1 1 0 0", k, lat, er, rd, wes); end
    end
  endtask

  task automatic test_back_to_back;
    do_req(1'b0, 3'b010, 32'hC, 32'h0, lat, rd, er, wes, wa, wdo);
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin errors++; $display("FAIL b2b_idle got v=%b r=%b d=%h e=%b want 0 1 0 0", rsp_valid, req_ready, rsp_rdata, rsp_err); end
    do_req(1'b0, 3'b010, 32'h4, 32'h0, lat, rd, er, wes, wa, wdo);
    checks++; if (lat !== 3 || rd !== 32'h1122AB44) begin errors++; $display("FAIL b2b_second got lat=%0d d=%h want 3 1122ab44", lat, rd); end
  endtask

  task automatic test_reset_mid_rmw;
    preload(2'd2, 32'hCAFEF00D);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b001; req_addr = 32'h8; req_wdata = 32'h00005555;
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rmw_busy got ready=%b want 0", req_ready); end
    repeat (2) begin @(posedge clk); #1; end
    checks++; if (we0 !== 1'b1) begin errors++; $display("FAIL rmw_stwr got we0=%b want 1", we0); end
    rst = 1'b1;
    #1;
    checks++; if (we0 !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL rmw_async got we=%b v=%b r=%b want 0 0 1", we0, rsp_valid, req_ready); end
    repeat (2) begin @(posedge clk); #1; end
    checks++; if (rsp_valid !== 1'b0 || mem[2] !== 32'hCAFEF00D) begin errors++; $display("FAIL rmw_mem got v=%b m=%h want 0 cafef00d", rsp_valid, mem[2]); end
    @(negedge clk);
    rst = 1'b0;
    do_req(1'b0, 3'b010, 32'h8, 32'h0, lat, rd, er, wes, wa, wdo);
    checks++; if (lat !== 3 || rd !== 32'hCAFEF00D) begin errors++; $display("FAIL rmw_readback got lat=%0d d=%h want 3 cafef00d", lat, rd); end
  endtask

  initial begin
    test_reset;
    test_lw;
    test_lb_lbu;
    test_sb;
    test_sw_half;
    test_errors;
    test_back_to_back;
    test_reset_mid_rmw;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
